// File: rtl/div_unit_pkg.sv
// Shared definitions for the EXE-stage multi-cycle divider.
package div_unit_pkg;

    // Bit positions inside div_op
    localparam int unsigned DivOpRem = 0;  // 1 = remainder, 0 = quotient
    localparam int unsigned DivOpUns = 1;  // 1 = unsigned, 0 = signed

    // Iteration counter width and its terminal value
    localparam int unsigned DivCntW = 5;
    localparam logic [DivCntW-1:0] DivCntLast = 5'd31;

    typedef enum logic [1:0] {
        DivIdle = 2'd0,
        DivBusy = 2'd1,
        DivDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;

    // Trial subtract is one bit wider than the remainder so its sign is always exact
    always_comb begin
        shifted  = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
        trial    = {rem_i, quo_i[WIDTH-1]} - {2'b00, divisor_i};
        trial_ok = ~trial[WIDTH+1];
        rem_o    = trial_ok ? trial[WIDTH:0] : shifted;
        quo_o    = {quo_i[WIDTH-2:0], trial_ok};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider with valid/ready handshakes on both sides.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       div_op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] div_result_o
);

    div_state_e         state_q;
    logic [DivCntW-1:0] cnt_q;
    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   src1_q;
    logic               rem_sel_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic               div_zero_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;

    logic [WIDTH:0]     rem_n;
    logic [WIDTH-1:0]   quo_n;
    logic               is_signed;
    logic               src1_neg;
    logic               src2_neg;
    logic [WIDTH-1:0]   src1_mag;
    logic [WIDTH-1:0]   src2_mag;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   result_d;

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(divisor_q),
        .rem_o    (rem_n),
        .quo_o    (quo_n)
    );

    // Operand signs and magnitudes presented at accept time
    always_comb begin
        is_signed = ~div_op_i[DivOpUns];
        src1_neg  = is_signed & src1_i[WIDTH-1];
        src2_neg  = is_signed & src2_i[WIDTH-1];
        src1_mag  = src1_neg ? (~src1_i + 1'b1) : src1_i;
        src2_mag  = src2_neg ? (~src2_i + 1'b1) : src2_i;
    end

    // Final result from the last step, with sign fix and divide-by-zero override
    always_comb begin
        quo_fix = neg_quo_q ? (~quo_n + 1'b1) : quo_n;
        rem_fix = neg_rem_q ? (~rem_n[WIDTH-1:0] + 1'b1) : rem_n[WIDTH-1:0];
        if (div_zero_q) begin
            quo_fix = '1;
            rem_fix = src1_q;
        end
        result_d = rem_sel_q ? rem_fix : quo_fix;
    end

    // Control FSM and datapath registers; handshake outputs are registered
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= DivIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            src1_q      <= '0;
            rem_sel_q   <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (flush_i) begin
            // Abort whatever is in flight; no result is produced
            state_q     <= DivIdle;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                DivIdle: begin
                    if (in_valid_i) begin
                        state_q    <= DivBusy;
                        cnt_q      <= '0;
                        rem_q      <= '0;
                        quo_q      <= src1_mag;
                        divisor_q  <= src2_mag;
                        src1_q     <= src1_i;
                        rem_sel_q  <= div_op_i[DivOpRem];
                        neg_quo_q  <= src1_neg ^ src2_neg;
                        neg_rem_q  <= src1_neg;
                        div_zero_q <= (src2_i == '0);
                        in_ready_q <= 1'b0;
                    end
                end
                DivBusy: begin
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == DivCntLast) begin
                        state_q     <= DivDone;
                        out_valid_q <= 1'b1;
                        result_q    <= result_d;
                    end
                end
                DivDone: begin
                    if (out_ready_i) begin
                        state_q     <= DivIdle;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= DivIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o   = in_ready_q;
    assign out_valid_o  = out_valid_q;
    assign div_result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  div_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] div_result;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OpDivW  = 2'b00;
    localparam logic [1:0] OpModW  = 2'b01;
    localparam logic [1:0] OpDivWu = 2'b10;
    localparam logic [1:0] OpModWu = 2'b11;

    always #5 clk = ~clk;

    div_unit #(
        .WIDTH(32)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .div_op_i    (div_op),
        .src1_i      (src1),
        .src2_i      (src2),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .div_result_o(div_result)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept one op, scramble inputs, wait (bounded) for out_valid; lat counts edges from accept
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        in_valid = 1'b1;
        div_op   = op;
        src1     = a;
        src2     = b;
        tick();
        in_valid = 1'b0;
        div_op   = ~op;
        src1     = 32'hDEADBEEF;
        src2     = 32'h00000000;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = div_result;
    endtask

    task automatic consume;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || div_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h, want 1 0 00000000",
                     in_ready, out_valid, div_result);
        end
    endtask

    task automatic test_arith;
        logic [1:0]  ops [12];
        logic [31:0] as  [12];
        logic [31:0] bs  [12];
        logic [31:0] exp [12];
        logic [31:0] res;
        int          lat;
        ops = '{OpDivW, OpModW, OpDivWu, OpModWu, OpDivW, OpModW,
                OpDivW, OpModW, OpModW, OpDivWu, OpDivW, OpModW};
        as  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000,
                32'h80000000, 32'h12345678, 32'h12345678, 32'hFFFFFFF9, 32'd100,
                32'hFFFFFFF9, 32'hFFFFFFF9};
        bs  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0,
                32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
        exp = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001, 32'h80000000,
                32'h00000000, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFF9, 32'd14,
                32'd3, 32'hFFFFFFFF};
        for (int i = 0; i < 12; i++) begin
            do_op(ops[i], as[i], bs[i], res, lat);
            checks++;
            if (res !== exp[i] || lat != 33) begin
                errors++;
                $display("FAIL arith[%0d]: result=%h latency=%0d, want %h 33",
                         i, res, lat, exp[i]);
            end
            consume();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL arith_release[%0d]: in_ready=%b out_valid=%b, want 1 0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] res;
        int          lat;
        do_op(OpDivWu, 32'd1000, 32'd3, res, lat);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || div_result !== 32'd333 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure[%0d]: out_valid=%b result=%h in_ready=%b, want 1 %h 0",
                         i, out_valid, div_result, in_ready, 32'd333);
            end
        end
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_flush;
        logic [31:0] res;
        int          lat;
        bit          pulse;
        // Accept in cycle T, flush in T+10
        in_valid = 1'b1;
        div_op   = OpDivW;
        src1     = 32'd50;
        src2     = 32'd5;
        tick();
        in_valid = 1'b0;
        pulse    = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (out_valid) pulse = 1'b1;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || pulse) begin
            errors++;
            $display("FAIL flush_idle: in_ready=%b out_valid=%b pulse=%b, want 1 0 0",
                     in_ready, out_valid, pulse);
        end
        // New op accepted in T+11 must return its own result
        do_op(OpModW, 32'hFFFFFF9C, 32'd7, res, lat);
        checks++;
        if (res !== 32'hFFFFFFFE || lat != 33) begin
            errors++;
            $display("FAIL flush_next_op: result=%h latency=%0d, want fffffffe 33", res, lat);
        end
        consume();
        // flush and in_valid together: not accepted
        in_valid = 1'b1;
        flush    = 1'b1;
        div_op   = OpDivWu;
        src1     = 32'd9;
        src2     = 32'd3;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        pulse    = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_with_valid: in_ready=%b, want 1", in_ready);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid || !in_ready) pulse = 1'b1;
        end
        checks++;
        if (pulse) begin
            errors++;
            $display("FAIL flush_with_valid_idle: spurious activity seen, want none");
        end
    endtask

    task automatic test_reset_busy;
        in_valid = 1'b1;
        div_op   = OpDivW;
        src1     = 32'd77;
        src2     = 32'd7;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] res;
        int          lat;
        out_ready = 1'b1;
        do_op(OpDivW, 32'd81, 32'hFFFFFFF7, res, lat);
        checks++;
        if (res !== 32'hFFFFFFF7 || lat != 33) begin
            errors++;
            $display("FAIL b2b_first: result=%h latency=%0d, want fffffff7 33", res, lat);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        do_op(OpModWu, 32'hFFFFFFFF, 32'd10, res, lat);
        checks++;
        if (res !== 32'd5 || lat != 33) begin
            errors++;
            $display("FAIL b2b_second: result=%h latency=%0d, want 00000005 33", res, lat);
        end
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        div_op    = 2'b00;
        src1      = '0;
        src2      = '0;
        test_reset();
        test_arith();
        test_backpressure();
        test_flush();
        test_reset_busy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider in the EXE stage, beside the single-cycle ALU. Executes LoongArch `div.w`, `mod.w`, `div.wu` and `mod.wu`. While a division is in flight, it stalls EXE through a valid/ready handshake. It returns quotient or remainder on a result port that EXE muxes with `alu_result` before the EXE→MEM register.

## Interface
- `WIDTH`, default 32: operand and result width; only 32 is supported.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `flush`  in  1  exception/ertn cancel; aborts any operation.
- `in_valid`  in  1  EXE presents a divide op.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `div_op`  in  2  bit0: 1 = remainder, 0 = quotient; bit1: 1 = unsigned, 0 = signed.
- `src1`  in  32  dividend (rj).
- `src2`  in  32  divisor (rk).
- `out_valid`  out  1  `div_result` is valid.
- `out_ready`  in  1  EXE consumes the result.
- `div_result`  out  32  quotient or remainder.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid & ~flush`, latch `div_op`, the operand signs and the operand magnitudes, then go to BUSY.
  - Signed mode uses the absolute value; unsigned mode uses the raw value.
- **BUSY:**
  - One restoring step per cycle, for 32 cycles, tracked by a 5-bit counter that runs 0..31.
  - Each step: shift partial remainder `{rem,quo}` left by 1, then compute trial = rem − divisor on 33 bits.
  - If trial is non-negative, rem = trial and the quotient LSB = 1; otherwise the quotient LSB = 0.
  - At count 31, go to DONE.
- **Sign fix, applied on DONE entry:**
  - Signed quotient is negated when sign(src1) ≠ sign(src2).
  - Signed remainder is negated when src1 is negative.
- **DONE:**
  - `out_valid`=1.
  - `div_result` holds its value until the cycle with `out_ready`=1, then the unit returns to IDLE.
- **Divisor zero, all ops:** override the result to quotient = 0xFFFFFFFF and remainder = src1. The unit still takes the full latency.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This falls out of the magnitude path and must not be special-cased.
- **`flush`:**
  - From any state, the next state is IDLE and `out_valid` drops next cycle.
  - No result is produced for the aborted op.
  - `flush` together with `in_valid` in IDLE: flush wins and the op is not accepted.

## Timing
- **Reset values:** state IDLE, `in_ready`=1, `out_valid`=0, `div_result`=0, counter=0.
- **Latency:** accept in cycle T; BUSY spans T+1..T+32; `out_valid` rises in T+33.
- **Throughput:** back-to-back accepts are possible. `out_ready` in T+33 gives `in_ready` in T+34.
- **Registered outputs:** `in_ready` and `out_valid` are decoded from the state register only, with no combinational path from `in_valid`/`out_ready`.
- **Handshake stability:** `src1`, `src2` and `div_op` are sampled only in the accept cycle; later changes are ignored.
- **DONE with `out_ready` low:** the unit stays in DONE indefinitely and `div_result` is stable.
- **Reset in BUSY or DONE:** the unit is back in IDLE the next cycle, and the prior op is lost.

## Structure
- **Shared header `mycpu.h`:**
  - `DIV_OP_REM` = bit 0 and `DIV_OP_UNS` = bit 1 positions.
  - FSM state encodings `DIV_IDLE`, `DIV_BUSY`, `DIV_DONE`.
- **Sub-module:** one combinational sub-module, `div_step`, implementing a single restoring iteration.
  - Inputs: 33-bit rem, 32-bit quo, divisor.
  - Outputs: next rem and next quo.
  - It is instantiated once in `div_unit`.
- **Decode:** decoding of `div_op` from the instruction stays in the ID stage, not in this unit.

## Test plan
- **Signed divide:** `div.w`, src1=0xFFFFFFF9 (−7), src2=2 → `div_result`=0xFFFFFFFD (−3) at T+33. `mod.w` with the same operands → 0xFFFFFFFF (−1).
- **Unsigned divide:** `div.wu`, src1=0xFFFFFFF9, src2=2 → 0x7FFFFFFC. `mod.wu` → 0x00000001.
- **Corner cases:**
  - `div.w` 0x80000000 / 0xFFFFFFFF → 0x80000000; `mod.w` → 0.
  - `div.w` with src2=0, src1=0x12345678 → 0xFFFFFFFF; `mod.w` → 0x12345678.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after DONE → `out_valid` and `div_result` stay stable and `in_ready`=0. Raising `out_ready` gives `in_ready`=1 the next cycle.
- **Flush:**
  - `flush` at T+10 → IDLE at T+11 with no `out_valid` pulse. A new op accepted at T+11 returns its own correct result at T+44.
  - `flush` and `in_valid` together in IDLE → not accepted.
- **Reset:** assert `reset` during BUSY → IDLE next cycle with `in_ready`=1 and `out_valid`=0. Back-to-back ops with `out_ready` tied high both complete with 33-cycle latency.
